// File: rtl/mult_arb_pkg.sv
// Shared constants, in-flight tag type and one-hot/index helpers for mult_arb.
// Requester ids are carried at the 8-requester width so the tag type needs no parameter.
package mult_arb_pkg;

    localparam int SIZE_DEF = 16;
    localparam int NREQ_DEF = 4;
    localparam int LAT_DEF  = 2;
    localparam int NMAX     = 8;
    localparam int IDW      = 3;

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } tag_t;

    function automatic logic [NMAX-1:0] onehot(input logic [IDW-1:0] id);
        onehot = NMAX'(1) << id;
    endfunction

    function automatic logic [IDW-1:0] index(input logic [NMAX-1:0] oh);
        index = '0;
        for (int i = 0; i < NMAX; i++) begin
            if (oh[i]) begin
                index = IDW'(i);
            end
        end
    endfunction

endpackage

// File: rtl/mult_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request above the last winner, wrapping.
// Latency: combinational. Backpressure: none; grant is all-zero when nothing requests.
// The grantee is whoever the caller gates in; the pointer update lives in the caller.
module mult_arb_rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] grant
);

    logic [NREQ-1:0] hi_req;
    logic [NREQ-1:0] pick;

    // Requests strictly above the last winner get priority; otherwise wrap to the bottom.
    always_comb begin
        hi_req = '0;
        for (int i = 0; i < NREQ; i++) begin
            hi_req[i] = req[i] && (i > int'(last));
        end
        pick  = (|hi_req) ? hi_req : req;
        grant = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (pick[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_arb.sv
// Shares one pipelined signed multiplier among NREQ requesters; MULT_ARB_STATS_EN adds grant counters.
// Latency: LAT cycles from handshake to one-cycle resp_valid strobe; one transfer per cycle.
// Backpressure: req_ready is the round-robin grant (zero during rst); responses cannot be stalled.
module mult_arb
    import mult_arb_pkg::*;
#(
    parameter int SIZE = SIZE_DEF,
    parameter int NREQ = NREQ_DEF,
    parameter int LAT  = LAT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*SIZE-1:0] req_a,
    input  logic [NREQ*SIZE-1:0] req_b,
    output logic [SIZE-1:0]      mul_a,
    output logic [SIZE-1:0]      mul_b,
    input  logic [SIZE-1:0]      mul_pdt,
    output logic [NREQ-1:0]      resp_valid,
    output logic [SIZE-1:0]      resp_pdt,
`ifdef MULT_ARB_STATS_EN
    input  logic [$clog2(NREQ)-1:0] stat_sel,
    output logic [15:0]             stat_cnt,
`endif
    output logic                 busy
);

    logic [IDW-1:0]  last_grant;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            xfer;
    logic [SIZE-1:0] sel_a;
    logic [SIZE-1:0] sel_b;
    tag_t            tag_q [LAT-1];

    mult_arb_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req_valid),
        .last  (last_grant),
        .grant (grant)
    );

    assign req_ready = rst ? '0 : grant;
    assign xfer      = |req_ready;
    assign grant_idx = index(NMAX'(req_ready));

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                sel_a = req_a[i*SIZE +: SIZE];
                sel_b = req_b[i*SIZE +: SIZE];
            end
        end
    end

    // Pointer starts at NREQ-1 so requester 0 wins the first arbitration after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a      <= '0;
            mul_b      <= '0;
            last_grant <= IDW'(NREQ - 1);
        end else if (xfer) begin
            mul_a      <= sel_a;
            mul_b      <= sel_b;
            last_grant <= grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT - 1; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0].vld <= xfer;
            tag_q[0].id  <= grant_idx;
            for (int i = 1; i < LAT - 1; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= '0;
            resp_pdt   <= '0;
        end else if (tag_q[LAT-2].vld) begin
            resp_valid <= NREQ'(onehot(tag_q[LAT-2].id));
            resp_pdt   <= mul_pdt;
        end else begin
            resp_valid <= '0;
        end
    end

    always_comb begin
        busy = |resp_valid;
        for (int i = 0; i < LAT - 1; i++) begin
            busy = busy | tag_q[i].vld;
        end
    end

`ifdef MULT_ARB_STATS_EN
    logic [15:0] grant_cnt [NREQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                grant_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) begin
                    grant_cnt[i] <= grant_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign stat_cnt = grant_cnt[stat_sel];
`endif

endmodule

// File: tb/tb_mult_arb.sv
// Bench for mult_arb: vector table for arbitration, scoreboard for responses, hand sequences for reset/withdraw.
module tb_mult_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic [15:0] mul_pdt = '0;
    logic [3:0]  resp_valid;
    logic [15:0] resp_pdt;
    logic        busy;
`ifdef MULT_ARB_STATS_EN
    logic [1:0]  stat_sel = 2'd3;
    logic [15:0] stat_cnt;
`endif

    mult_arb #(.SIZE(16), .NREQ(4), .LAT(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_pdt    (mul_pdt),
        .resp_valid (resp_valid),
        .resp_pdt   (resp_pdt),
`ifdef MULT_ARB_STATS_EN
        .stat_sel   (stat_sel),
        .stat_cnt   (stat_cnt),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] prod(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] p;
        p = $signed(a) * $signed(b);
        return p[15:0];
    endfunction

    // Environment multiplier: captures the registered operands on the falling edge.
    always @(negedge clk) mul_pdt <= prod(mul_a, mul_b);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    typedef struct {
        int          due;
        logic [3:0]  oh;
        logic [15:0] pdt;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [3:0]  v;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  rdy;
    } vec_t;
    vec_t tbl[16];

    task automatic apply(input logic [3:0] v, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] exp, input logic push, input string nm);
        sb_t e;
        @(posedge clk);
        #1;
        req_valid = v;
        req_a     = a;
        req_b     = b;
        #1;
        chk(nm, 32'(req_ready), 32'(exp));
        if (push && exp != 4'd0) begin
            e.due = cyc + 2;
            e.oh  = exp;
            e.pdt = '0;
            for (int i = 0; i < 4; i++) begin
                if (exp[i]) e.pdt = prod(a[i*16 +: 16], b[i*16 +: 16]);
            end
            sb.push_back(e);
        end
    endtask

    // Response monitor: every cycle either the scoreboard head is due or the strobe must be idle.
    initial begin
        sb_t e;
        forever begin
            @(posedge clk);
            #3;
            if (mon_en) begin
                if (sb.size() > 0 && sb[0].due == cyc) begin
                    e = sb.pop_front();
                    chk("resp_valid", 32'(resp_valid), 32'(e.oh));
                    chk("resp_pdt", 32'(resp_pdt), 32'(e.pdt));
                end else begin
                    chk("resp_idle", 32'(resp_valid), 32'd0);
                end
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #4;
        chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        string nm;
        for (int k = 0; k < 16; k++) begin
            tbl[k].a = {$urandom, $urandom};
            tbl[k].b = {$urandom, $urandom};
        end
        for (int k = 0; k < 8; k++) begin
            tbl[k].v   = 4'b1111;
            tbl[k].rdy = 4'b0001 << (k % 4);
        end
        tbl[8]  = '{v: 4'b0100, a: tbl[8].a,  b: tbl[8].b,  rdy: 4'b0100};
        tbl[8].a[2*16 +: 16] = 16'd3;
        tbl[8].b[2*16 +: 16] = 16'hFFFC;
        tbl[9]  = '{v: 4'b0100, a: tbl[9].a,  b: tbl[9].b,  rdy: 4'b0100};
        tbl[10] = '{v: 4'b0000, a: tbl[10].a, b: tbl[10].b, rdy: 4'b0000};
        tbl[11] = '{v: 4'b0011, a: tbl[11].a, b: tbl[11].b, rdy: 4'b0001};
        tbl[11].a[15:0]  = 16'h4000;
        tbl[11].b[15:0]  = 16'h0004;
        tbl[11].a[31:16] = 16'hFFFF;
        tbl[11].b[31:16] = 16'hFFFF;
        tbl[12] = '{v: 4'b0011, a: tbl[11].a, b: tbl[11].b, rdy: 4'b0010};
        tbl[13] = '{v: 4'b1010, a: tbl[13].a, b: tbl[13].b, rdy: 4'b1000};
        tbl[14] = '{v: 4'b1010, a: tbl[14].a, b: tbl[14].b, rdy: 4'b0010};
        tbl[15] = '{v: 4'b0000, a: tbl[15].a, b: tbl[15].b, rdy: 4'b0000};

        rst       = 1'b1;
        req_valid = 4'b1111;
        req_a     = {$urandom, $urandom};
        req_b     = {$urandom, $urandom};
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_pdt", 32'(resp_pdt), 32'd0);
        chk("rst_mul_a", 32'(mul_a), 32'd0);
        chk("rst_mul_b", 32'(mul_b), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
`ifdef MULT_ARB_STATS_EN
        chk("rst_stat_cnt", 32'(stat_cnt), 32'd0);
`endif
        rst       = 1'b0;
        req_valid = 4'b0000;
        mon_en    = 1'b1;

        for (int k = 0; k < 16; k++) begin
            nm = $sformatf("vec%0d_ready", k);
            apply(tbl[k].v, tbl[k].a, tbl[k].b, tbl[k].rdy, 1'b1, nm);
        end
        drain();

        // Transfer to requester 0, then reset before its product returns.
        apply(4'b0001, {$urandom, $urandom}, {$urandom, $urandom}, 4'b0001, 1'b0, "pre_rst_ready");
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("midrst_ready", 32'(req_ready), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 4'b0000;
        #1;
        chk("postrst_busy", 32'(busy), 32'd0);
        chk("postrst_resp", 32'(resp_valid), 32'd0);

        // Requester 1 withdraws after losing; only requester 0 may be answered.
        apply(4'b0011, {$urandom, $urandom}, {$urandom, $urandom}, 4'b0001, 1'b1, "postrst_grant0");
        apply(4'b0000, {$urandom, $urandom}, {$urandom, $urandom}, 4'b0000, 1'b1, "withdraw_ready");
        apply(4'b0000, req_a, req_b, 4'b0000, 1'b1, "idle_ready");
        drain();
        #1;
        chk("idle_busy", 32'(busy), 32'd0);

`ifdef MULT_ARB_STATS_EN
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 4'b1000;
        repeat (65537) @(posedge clk);
        #1;
        req_valid = 4'b0000;
        stat_sel  = 2'd3;
        #1;
        chk("stat_wrap3", 32'(stat_cnt), 32'd1);
        stat_sel = 2'd0;
        #1;
        chk("stat_cnt0", 32'(stat_cnt), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_arb.md
# mult_arb

Round-robin controller that shares one two-stage signed multiplier among NREQ requesting processing elements. Accepts at most one operand pair per cycle via valid/ready, drives the shared multiplier from registered operands, tracks the owner of each in-flight product through a tag pipeline, and returns the trimmed product to the originating requester. Sits between the PE operand sources and the single multiplier instance in a PE cluster.

## Interface
- SIZE, 16, operand and product width
- NREQ, 4, number of requesters (2..8)
- LAT, 2, cycles from accepted handshake to response; must match the multiplier instance
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  one-hot grant; at most one bit high
- req_a  in  NREQ*SIZE  signed multiplicands, requester i at bits [i*SIZE +: SIZE]
- req_b  in  NREQ*SIZE  signed multipliers, same packing
- mul_a  out  SIZE  registered operand to multiplier
- mul_b  out  SIZE  registered operand to multiplier
- mul_pdt  in  SIZE  trimmed product from multiplier
- resp_valid  out  NREQ  one-hot response strobe, one cycle
- resp_pdt  out  SIZE  product for the strobed requester
- busy  out  1  high while any tag is in flight

## Operation
- Arbitration: combinational round-robin over req_valid; search begins at last_grant+1 modulo NREQ; req_ready is the one-hot winner; all-zero when no valid.
- Handshake: transfer occurs when req_valid[i] & req_ready[i]; requester must hold a/b stable while valid and not yet granted; valid may drop without transfer.
- On transfer: mul_a/mul_b <= selected operands; last_grant <= i; tag pipe stage 0 <= {1, i}.
- Tag pipe: LAT-1 deep shift register of {vld, id}; shifts every cycle; bubble {0, x} when no transfer.
- Response: when final tag vld, resp_pdt <= mul_pdt, resp_valid <= onehot(id); otherwise resp_valid <= 0, resp_pdt holds.
- No response backpressure; requesters must accept resp_valid in the cycle it is high.
- Product arithmetic is done by the multiplier (low SIZE bits of the signed 2*SIZE product); this block only routes it.
- busy = OR of tag valid bits and resp_valid.
- Reset values: req_ready 0 (no grants while rst), resp_valid 0, resp_pdt 0, mul_a 0, mul_b 0, busy 0, last_grant NREQ-1 (requester 0 wins first).
- Reset mid-operation: all in-flight tags cleared; their products are never returned.

## Timing
- Cycle t: handshake. Posedge ending t: mul_a/mul_b registered. Multiplier captures during t+1 (negedge). Posedge ending t+1: resp registered. Cycle t+2: resp_valid high → LAT = 2.
- Throughput: one transfer per cycle, fully pipelined; back-to-back grants to the same requester allowed only when it is the sole valid requester.
- Fairness: with all NREQ valid continuously, each requester granted exactly once per NREQ cycles.
- Simultaneous transfer and response in the same cycle: independent, both occur.

## Configuration
- MULT_ARB_STATS_EN defined: per-requester 16-bit grant counters, increment on transfer, wrap 0xFFFF→0, cleared on rst; extra ports stat_sel (in, clog2(NREQ)) and stat_cnt (out, 16, combinational read of selected counter).
- Undefined: no counters, no stat ports.

## Structure
- Package mult_arb_pkg: default SIZE/NREQ/LAT constants, tag struct {vld, id}, onehot/index helper functions.
- One sub-module: rr_arbiter (NREQ-wide, req vector + last pointer in, one-hot grant out, purely combinational).
- Top holds operand registers, tag pipe, response register, optional counters.

## Test plan
- Single request: requester 2 valid, a=3, b=-4 → req_ready=0100 same cycle; resp_valid=0100, resp_pdt=0xFFF4 two cycles later.
- All four valid continuously for 8 cycles → grant order 0,1,2,3,0,1,2,3; responses in same order, each LAT later.
- Overflow trim: a=0x4000, b=0x0004 → resp_pdt=0x0000; a=-1, b=-1 → 0x0001.
- Reset asserted one cycle after transfer → no resp_valid afterwards, busy=0, next grant goes to requester 0.
- Valid withdrawn: requester 1 valid one cycle while requester 0 wins, then drops → no response to requester 1.
- With MULT_ARB_STATS_EN: 65537 grants to requester 3 → stat_sel=3 reads stat_cnt=1.
